// File: rtl/cpu_pkg.sv
// cpu_pkg: shared pipeline constants, ID/EXE control struct and the source-match helper.
package cpu_pkg;
    localparam int DATA_W = 32;
    localparam int RIDX_W = 5;
    localparam int CMD_W  = 4;
    localparam int SHOP_W = 12;

    localparam logic [CMD_W-1:0] EXE_CMD_MOV = 4'b0001;
    localparam logic [CMD_W-1:0] EXE_CMD_MVN = 4'b1001;
    localparam logic [CMD_W-1:0] EXE_CMD_ADD = 4'b0010;
    localparam logic [CMD_W-1:0] EXE_CMD_ADC = 4'b0011;
    localparam logic [CMD_W-1:0] EXE_CMD_SUB = 4'b0100;
    localparam logic [CMD_W-1:0] EXE_CMD_SBC = 4'b0101;
    localparam logic [CMD_W-1:0] EXE_CMD_AND = 4'b0110;
    localparam logic [CMD_W-1:0] EXE_CMD_ORR = 4'b0111;
    localparam logic [CMD_W-1:0] EXE_CMD_EOR = 4'b1000;

    typedef struct packed {
        logic             valid;
        logic             wb_en;
        logic             mem_r_en;
        logic             mem_w_en;
        logic             b;
        logic             s;
        logic [CMD_W-1:0] exe_cmd;
    } id_exe_ctrl_t;

    localparam id_exe_ctrl_t ID_EXE_BUBBLE = '0;

    // r0 is hardwired, so a producer targeting index 0 never creates a dependency
    function automatic logic src_match(input logic [RIDX_W-1:0] dest, src1, src2, st_src,
                                       input logic two_src, st_en);
        return (dest != '0) && (dest == src1 || (two_src && dest == src2) || (st_en && dest == st_src));
    endfunction
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational RAW hazard detection for the ID instruction against EXE and MEM.
module load_use_detect
    import cpu_pkg::*;
(
    input  logic              forward_en,
    input  logic              exe_valid,
    input  logic              exe_mem_r_en,
    input  logic              exe_wb_en,
    input  logic [RIDX_W-1:0] exe_dest,
    input  logic              mem_wb_en,
    input  logic [RIDX_W-1:0] mem_dest,
    input  logic [RIDX_W-1:0] id_src1,
    input  logic [RIDX_W-1:0] id_src2,
    input  logic [RIDX_W-1:0] id_st_src,
    input  logic              id_is_two_source,
    input  logic              id_mem_w_en,
    output logic              hazard_raw
);
    logic exe_m, mem_m;

    assign exe_m = src_match(exe_dest, id_src1, id_src2, id_st_src, id_is_two_source, id_mem_w_en);
    assign mem_m = src_match(mem_dest, id_src1, id_src2, id_st_src, id_is_two_source, id_mem_w_en);
    // without forwarding every in-flight writer blocks; with it only a load in EXE does
    assign hazard_raw = (exe_valid & exe_m & (exe_mem_r_en | (~forward_en & exe_wb_en)))
                      | (~forward_en & mem_wb_en & mem_m);
endmodule

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: ID->EXE pipeline register with freeze/flush/load-use bubble priority
// and a saturating bubble counter.
module id_exe_stage_reg
    import cpu_pkg::*;
#(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int RIDX_W = cpu_pkg::RIDX_W,
    parameter int CMD_W  = cpu_pkg::CMD_W,
    parameter int SHOP_W = cpu_pkg::SHOP_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              flush,
    input  logic              forward_en,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [DATA_W-1:0] id_val_rn,
    input  logic [DATA_W-1:0] id_val_rm,
    input  logic [RIDX_W-1:0] id_src1,
    input  logic [RIDX_W-1:0] id_src2,
    input  logic [RIDX_W-1:0] id_st_src,
    input  logic [RIDX_W-1:0] id_dest,
    input  logic [CMD_W-1:0]  id_exe_cmd,
    input  logic              id_mem_r_en,
    input  logic              id_mem_w_en,
    input  logic              id_wb_en,
    input  logic              id_b,
    input  logic              id_s,
    input  logic              id_imm,
    input  logic [SHOP_W-1:0] id_shift_operand,
    input  logic              id_is_two_source,
    input  logic [3:0]        id_status,
    input  logic [RIDX_W-1:0] mem_dest,
    input  logic              mem_wb_en,
    output logic              exe_valid,
    output logic [DATA_W-1:0] exe_pc,
    output logic [DATA_W-1:0] exe_val_rn,
    output logic [DATA_W-1:0] exe_val_rm,
    output logic [RIDX_W-1:0] exe_src1,
    output logic [RIDX_W-1:0] exe_src2,
    output logic [RIDX_W-1:0] exe_st_src,
    output logic [RIDX_W-1:0] exe_dest,
    output logic [CMD_W-1:0]  exe_exe_cmd,
    output logic              exe_mem_r_en,
    output logic              exe_mem_w_en,
    output logic              exe_wb_en,
    output logic              exe_b,
    output logic              exe_s,
    output logic              exe_imm,
    output logic [SHOP_W-1:0] exe_shift_operand,
    output logic              exe_is_two_source,
    output logic [3:0]        exe_status,
    output logic              hazard_stall,
    output logic [CNT_W-1:0]  bubble_cnt
);
    id_exe_ctrl_t      ctrl_d, ctrl_q;
    logic [DATA_W-1:0] pc_d, pc_q, rn_d, rn_q, rm_d, rm_q;
    logic [RIDX_W-1:0] src1_d, src1_q, src2_d, src2_q, st_d, st_q, dest_d, dest_q;
    logic [SHOP_W-1:0] shop_d, shop_q;
    logic              imm_d, imm_q, two_d, two_q;
    logic [3:0]        status_d, status_q;
    logic [CNT_W-1:0]  cnt_d, cnt_q;
    logic              hazard_raw, kill;

    load_use_detect u_lud (
        .forward_en       (forward_en),
        .exe_valid        (ctrl_q.valid),
        .exe_mem_r_en     (ctrl_q.mem_r_en),
        .exe_wb_en        (ctrl_q.wb_en),
        .exe_dest         (dest_q),
        .mem_wb_en        (mem_wb_en),
        .mem_dest         (mem_dest),
        .id_src1          (id_src1),
        .id_src2          (id_src2),
        .id_st_src        (id_st_src),
        .id_is_two_source (id_is_two_source),
        .id_mem_w_en      (id_mem_w_en),
        .hazard_raw       (hazard_raw)
    );

    // flush outranks the hazard, so a flushed instruction never counts a bubble
    assign hazard_stall = id_valid & ~flush & hazard_raw;
    assign kill         = flush | hazard_stall;

    always_comb begin
        ctrl_d   = kill ? ID_EXE_BUBBLE : '{valid: id_valid, wb_en: id_wb_en, mem_r_en: id_mem_r_en,
                                            mem_w_en: id_mem_w_en, b: id_b, s: id_s, exe_cmd: id_exe_cmd};
        pc_d     = kill ? '0 : id_pc;
        rn_d     = kill ? '0 : id_val_rn;
        rm_d     = kill ? '0 : id_val_rm;
        src1_d   = kill ? '0 : id_src1;
        src2_d   = kill ? '0 : id_src2;
        st_d     = kill ? '0 : id_st_src;
        dest_d   = kill ? '0 : id_dest;
        shop_d   = kill ? '0 : id_shift_operand;
        imm_d    = kill ? 1'b0 : id_imm;
        two_d    = kill ? 1'b0 : id_is_two_source;
        status_d = kill ? '0 : id_status;
        cnt_d    = (hazard_stall && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= ID_EXE_BUBBLE;
            pc_q     <= '0;
            rn_q     <= '0;
            rm_q     <= '0;
            src1_q   <= '0;
            src2_q   <= '0;
            st_q     <= '0;
            dest_q   <= '0;
            shop_q   <= '0;
            imm_q    <= 1'b0;
            two_q    <= 1'b0;
            status_q <= '0;
            cnt_q    <= '0;
        end else if (!freeze) begin
            ctrl_q   <= ctrl_d;
            pc_q     <= pc_d;
            rn_q     <= rn_d;
            rm_q     <= rm_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            st_q     <= st_d;
            dest_q   <= dest_d;
            shop_q   <= shop_d;
            imm_q    <= imm_d;
            two_q    <= two_d;
            status_q <= status_d;
            cnt_q    <= cnt_d;
        end
    end

    assign exe_valid         = ctrl_q.valid;
    assign exe_wb_en         = ctrl_q.wb_en;
    assign exe_mem_r_en      = ctrl_q.mem_r_en;
    assign exe_mem_w_en      = ctrl_q.mem_w_en;
    assign exe_b             = ctrl_q.b;
    assign exe_s             = ctrl_q.s;
    assign exe_exe_cmd       = ctrl_q.exe_cmd;
    assign exe_pc            = pc_q;
    assign exe_val_rn        = rn_q;
    assign exe_val_rm        = rm_q;
    assign exe_src1          = src1_q;
    assign exe_src2          = src2_q;
    assign exe_st_src        = st_q;
    assign exe_dest          = dest_q;
    assign exe_shift_operand = shop_q;
    assign exe_imm           = imm_q;
    assign exe_is_two_source = two_q;
    assign exe_status        = status_q;
    assign bubble_cnt        = cnt_q;
endmodule

// File: tb/tb_id_exe_stage_reg.sv
// tb_id_exe_stage_reg: randomized + directed scoreboard bench for id_exe_stage_reg,
// checked against an abstract model of the EXE slot and bubble count.
module tb_id_exe_stage_reg;
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, rn, rm;
        logic [4:0]  src1, src2, st_src, dest;
        logic [3:0]  cmd;
        logic        r, w, wb, b, s, imm;
        logic [11:0] shop;
        logic        two;
        logic [3:0]  status;
    } rec_t;
    typedef struct packed {
        rec_t       e;
        logic [7:0] cnt;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, freeze = 1'b0, flush = 1'b0, forward_en = 1'b1;
    rec_t idr = '0;
    logic [4:0] mem_dest = '0;
    logic mem_wb_en = 1'b0;

    logic exe_valid, exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b, exe_s, exe_imm, exe_is_two_source;
    logic [31:0] exe_pc, exe_val_rn, exe_val_rm;
    logic [4:0] exe_src1, exe_src2, exe_st_src, exe_dest;
    logic [3:0] exe_exe_cmd, exe_status;
    logic [11:0] exe_shift_operand;
    logic hazard_stall;
    logic [7:0] bubble_cnt;
    rec_t act;

    exp_t q[$];
    rec_t m_exe = '0;
    int m_cnt = 0;
    int tests = 0, fails = 0;

    id_exe_stage_reg #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush), .forward_en(forward_en),
        .id_valid(idr.valid), .id_pc(idr.pc), .id_val_rn(idr.rn), .id_val_rm(idr.rm),
        .id_src1(idr.src1), .id_src2(idr.src2), .id_st_src(idr.st_src), .id_dest(idr.dest),
        .id_exe_cmd(idr.cmd), .id_mem_r_en(idr.r), .id_mem_w_en(idr.w), .id_wb_en(idr.wb),
        .id_b(idr.b), .id_s(idr.s), .id_imm(idr.imm), .id_shift_operand(idr.shop),
        .id_is_two_source(idr.two), .id_status(idr.status),
        .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
        .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_val_rn(exe_val_rn), .exe_val_rm(exe_val_rm),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_st_src(exe_st_src), .exe_dest(exe_dest),
        .exe_exe_cmd(exe_exe_cmd), .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
        .exe_wb_en(exe_wb_en), .exe_b(exe_b), .exe_s(exe_s), .exe_imm(exe_imm),
        .exe_shift_operand(exe_shift_operand), .exe_is_two_source(exe_is_two_source),
        .exe_status(exe_status), .hazard_stall(hazard_stall), .bubble_cnt(bubble_cnt)
    );

    assign act = {exe_valid, exe_pc, exe_val_rn, exe_val_rm, exe_src1, exe_src2, exe_st_src, exe_dest,
                  exe_exe_cmd, exe_mem_r_en, exe_mem_w_en, exe_wb_en, exe_b, exe_s, exe_imm,
                  exe_shift_operand, exe_is_two_source, exe_status};

    always #5 clk = ~clk;

    // reads/producers collected as lists; any nonzero producer found among the reads is a hazard
    function automatic logic model_hazard(rec_t e, rec_t i, logic fe, logic [4:0] md, logic mwb, logic fl);
        logic [4:0] reads[$];
        logic [4:0] prods[$];
        if (!i.valid || fl) return 1'b0;
        reads.push_back(i.src1);
        if (i.two) reads.push_back(i.src2);
        if (i.w) reads.push_back(i.st_src);
        if (e.valid && (e.r || (!fe && e.wb))) prods.push_back(e.dest);
        if (!fe && mwb) prods.push_back(md);
        foreach (prods[p]) if (prods[p] != 0) foreach (reads[k]) if (reads[k] == prods[p]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic rec_t rnd();
        rec_t x;
        x.valid = ($urandom % 4) != 0;
        x.pc = $urandom; x.rn = $urandom; x.rm = $urandom;
        x.src1 = 5'($urandom_range(0, 7)); x.src2 = 5'($urandom_range(0, 7));
        x.st_src = 5'($urandom_range(0, 7)); x.dest = 5'($urandom_range(0, 7));
        x.cmd = 4'($urandom); x.r = 1'($urandom); x.w = 1'($urandom); x.wb = 1'($urandom);
        x.b = 1'($urandom); x.s = 1'($urandom); x.imm = 1'($urandom);
        x.shop = 12'($urandom); x.two = 1'($urandom); x.status = 4'($urandom);
        return x;
    endfunction

    function automatic rec_t mk(logic [4:0] dest, s1, s2, logic two, r, w, wb);
        rec_t x = rnd();
        x.valid = 1'b1; x.dest = dest; x.src1 = s1; x.src2 = s2; x.two = two;
        x.r = r; x.w = w; x.wb = wb; x.st_src = 5'd0;
        return x;
    endfunction

    task automatic check_zero();
        tests++;
        if (act !== '0) begin fails++; $display("FAIL reset_exe got %h want 0", act); end
        tests++;
        if (bubble_cnt !== 8'd0) begin fails++; $display("FAIL reset_cnt got %0d want 0", bubble_cnt); end
    endtask

    task automatic drive(input rec_t nid, input logic fz, fl, fe, input logic [4:0] md, input logic mwb,
                         input logic rst_pulse = 1'b0);
        logic h;
        @(negedge clk);
        idr = nid; freeze = fz; flush = fl; forward_en = fe; mem_dest = md; mem_wb_en = mwb;
        if (rst_pulse) begin
            #1 rst_n = 1'b0;
            #1 check_zero();
            q.delete(); m_exe = '0; m_cnt = 0;
            rst_n = 1'b1;
        end
        h = model_hazard(m_exe, nid, fe, md, mwb, fl);
        #1;
        tests++;
        if (hazard_stall !== h) begin
            fails++; $display("FAIL hazard_stall t=%0t got %b want %b", $time, hazard_stall, h);
        end
        if (!fz) begin
            if (fl || h) begin
                m_exe = '0;
                if (h && m_cnt < 255) m_cnt++;
            end else m_exe = nid;
        end
        q.push_back('{m_exe, 8'(m_cnt)});
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            tests++;
            if (act !== x.e) begin fails++; $display("FAIL exe_regs t=%0t got %h want %h", $time, act, x.e); end
            tests++;
            if (bubble_cnt !== x.cnt) begin
                fails++; $display("FAIL bubble_cnt t=%0t got %0d want %0d", $time, bubble_cnt, x.cnt);
            end
        end
    end

    initial begin
        rec_t ldr, alu;
        #6 check_zero();
        @(negedge clk) rst_n = 1'b1;
        ldr = mk(5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        alu = mk(5'd5, 5'd3, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(ldr, 0, 0, 1, 0, 0);
        drive(alu, 0, 0, 1, 0, 0);
        drive(alu, 0, 0, 1, 0, 0);
        drive(mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1), 0, 0, 1, 0, 0);
        drive(mk(5'd9, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1), 0, 0, 1, 0, 0);
        ldr = mk(5'd4, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        drive(ldr, 0, 0, 1, 0, 0);
        drive(mk(5'd6, 5'd2, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1), 0, 0, 1, 0, 0);
        drive(ldr, 0, 0, 1, 0, 0);
        alu = mk(5'd6, 5'd2, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(alu, 0, 0, 1, 0, 0);
        drive(alu, 0, 0, 1, 0, 0);
        ldr = mk(5'd3, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        alu = mk(5'd5, 5'd3, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(ldr, 0, 0, 1, 0, 0);
        drive(alu, 0, 1, 1, 0, 0);
        drive(ldr, 0, 0, 1, 0, 0);
        drive(alu, 1, 1, 1, 0, 0);
        drive(alu, 1, 1, 1, 0, 0);
        drive(mk(5'd7, 5'd1, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1), 0, 0, 0, 0, 0);
        alu = mk(5'd8, 5'd7, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        drive(alu, 0, 0, 0, 0, 0);
        drive(alu, 0, 0, 0, 5'd7, 1);
        drive(alu, 0, 0, 0, 0, 0);
        repeat (600) drive(rnd(), ($urandom % 10) == 0, ($urandom % 10) == 0, 1'($urandom),
                           5'($urandom_range(0, 7)), 1'($urandom));
        drive(rnd(), 0, 0, 1, 0, 0, 1'b1);
        repeat (20) drive(rnd(), 0, ($urandom % 8) == 0, 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom));
        alu = mk(5'd9, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        repeat (300) drive(alu, 0, 0, 0, 5'd5, 1);
        drive(alu, 1, 0, 0, 5'd5, 1);
        drive(rnd(), 0, 0, 1, 0, 0);
        @(posedge clk);
        #2;
        tests++;
        if (q.size() != 0) begin fails++; $display("FAIL scoreboard_drain got %0d want 0", q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
